branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit_if.sv | 32 +++
 rtl/branch_predict_unit.sv | 102 ++++++++++
 tb/tb_branch_predict_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_if.sv
// Signal bundle between the pipeline and branch_predict_unit: fetch lookup,
// execute-stage resolution inputs, resolution pulses and statistics.
interface branch_predict_unit_if #(
   parameter int PC_WIDTH  = 16,
   parameter int CNT_WIDTH = 16
);
   logic [PC_WIDTH-1:0]  pc_f;
   logic                 predict_taken_f;
   logic                 branch_e;
   logic [3:0]           cond_e;
   logic [PC_WIDTH-1:0]  pc_e;
   logic                 pred_taken_e;
   logic                 Z;
   logic                 N;
   logic                 V;
   logic                 C;
   logic                 stall_e;
   logic                 PC_source;
   logic                 mispredict;
   logic [CNT_WIDTH-1:0] branch_count;
   logic [CNT_WIDTH-1:0] mispredict_count;

   modport master (
      output pc_f, branch_e, cond_e, pc_e, pred_taken_e, Z, N, V, C, stall_e,
      input  predict_taken_f, PC_source, mispredict, branch_count, mispredict_count
   );

   modport slave (
      input  pc_f, branch_e, cond_e, pc_e, pred_taken_e, Z, N, V, C, stall_e,
      output predict_taken_f, PC_source, mispredict, branch_count, mispredict_count
   );
endinterface

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: 2-bit saturating history table read at fetch,
// trained at execute, with a one-cycle registered taken/mispredict pulse.
module branch_predict_unit #(
   parameter int PC_WIDTH  = 16,
   parameter int BHT_DEPTH = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   branch_predict_unit_if.slave bus
);
   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic [1:0]           r_bht [BHT_DEPTH];
   logic                 r_pc_source_p1;
   logic                 r_mispredict_p1;
   logic [CNT_WIDTH-1:0] r_branch_count;
   logic [CNT_WIDTH-1:0] r_mispredict_count;

   logic [IDX_W-1:0]     w_idx_f;
   logic [IDX_W-1:0]     w_idx_e;
   logic                 w_resolve;
   logic                 w_taken;
   logic                 w_miss;

   function automatic logic f_cond_taken(input logic [3:0] cond,
                                         input logic z, input logic n,
                                         input logic v, input logic c);
      logic t;
      case (cond)
         4'h0:    t = z;
         4'h1:    t = ~z;
         4'h2:    t = c;
         4'h3:    t = ~c;
         4'h4:    t = n;
         4'h5:    t = ~n;
         4'h6:    t = v;
         4'h7:    t = ~v;
         4'h8:    t = c & ~z;
         4'h9:    t = ~c | z;
         4'hA:    t = ~(n ^ v);
         4'hB:    t = n ^ v;
         4'hC:    t = ~z & ~(n ^ v);
         4'hD:    t = z | (n ^ v);
         4'hE:    t = 1'b0;
         default: t = 1'b1;
      endcase
      return t;
   endfunction

   function automatic logic [1:0] f_bht_train(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      if (taken) nxt = (ctr == 2'b11) ? ctr : ctr + 2'b01;
      else       nxt = (ctr == 2'b00) ? ctr : ctr - 2'b01;
      return nxt;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] f_cnt_sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Upper PC bits do not participate in indexing.
   generate
      if (PC_WIDTH > IDX_W) begin : g_pc_hi
         logic w_unused_pc_hi;
         assign w_unused_pc_hi = ^{bus.pc_f[PC_WIDTH-1:IDX_W], bus.pc_e[PC_WIDTH-1:IDX_W]};
      end
   endgenerate

   assign w_idx_f   = bus.pc_f[IDX_W-1:0];
   assign w_idx_e   = bus.pc_e[IDX_W-1:0];
   assign w_resolve = bus.branch_e & ~bus.stall_e;
   assign w_taken   = f_cond_taken(bus.cond_e, bus.Z, bus.N, bus.V, bus.C);
   assign w_miss    = w_taken ^ bus.pred_taken_e;

   // Fetch lookup reads the array directly, so a same-cycle update is not visible.
   assign bus.predict_taken_f = r_bht[w_idx_f][1];

   // Resolve stage -> registered pulses, table training and statistics
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
         r_pc_source_p1     <= 1'b0;
         r_mispredict_p1    <= 1'b0;
         r_branch_count     <= '0;
         r_mispredict_count <= '0;
      end else begin
         r_pc_source_p1  <= w_resolve & w_taken;
         r_mispredict_p1 <= w_resolve & w_miss;
         if (w_resolve) begin
            r_bht[w_idx_e] <= f_bht_train(r_bht[w_idx_e], w_taken);
            r_branch_count <= f_cnt_sat_inc(r_branch_count);
            if (w_miss) r_mispredict_count <= f_cnt_sat_inc(r_mispredict_count);
         end
      end
   end

   assign bus.PC_source        = r_pc_source_p1;
   assign bus.mispredict       = r_mispredict_p1;
   assign bus.branch_count     = r_branch_count;
   assign bus.mispredict_count = r_mispredict_count;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: a 16-bit-counter instance and a
// 4-bit-counter instance share stimulus and are compared to a behavioural model.
module tb_branch_predict_unit;
   localparam int PCW   = 16;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   branch_predict_unit_if #(.PC_WIDTH(PCW), .CNT_WIDTH(16)) bus ();
   branch_predict_unit_if #(.PC_WIDTH(PCW), .CNT_WIDTH(4))  bus4 ();

   assign bus4.pc_f         = bus.pc_f;
   assign bus4.branch_e     = bus.branch_e;
   assign bus4.cond_e       = bus.cond_e;
   assign bus4.pc_e         = bus.pc_e;
   assign bus4.pred_taken_e = bus.pred_taken_e;
   assign bus4.Z            = bus.Z;
   assign bus4.N            = bus.N;
   assign bus4.V            = bus.V;
   assign bus4.C            = bus.C;
   assign bus4.stall_e      = bus.stall_e;

   branch_predict_unit #(.PC_WIDTH(PCW), .BHT_DEPTH(DEPTH), .CNT_WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));
   branch_predict_unit #(.PC_WIDTH(PCW), .BHT_DEPTH(DEPTH), .CNT_WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4.slave));

   // Reference model: counter strength per entry, plain integer statistics.
   int m_bht [DEPTH];
   int m_bcnt;
   int m_mcnt;
   bit m_pcs;
   bit m_mis;

   function automatic bit model_taken(input logic [3:0] cond, input bit z, input bit n,
                                      input bit v, input bit c);
      bit base;
      // Odd codes are the complement of the preceding even code.
      case (cond[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b0;
      endcase
      return base ^ cond[0];
   endfunction

   function automatic bit model_pred(input logic [PCW-1:0] pc);
      return m_bht[int'(pc) % DEPTH] >= 2;
   endfunction

   function automatic int sat4(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   task automatic clk_step();
      bit res, tk, mis;
      int idx;
      res = bus.branch_e && !bus.stall_e;
      tk  = model_taken(bus.cond_e, bus.Z, bus.N, bus.V, bus.C);
      mis = tk ^ bus.pred_taken_e;
      idx = int'(bus.pc_e) % DEPTH;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
         m_bcnt = 0; m_mcnt = 0; m_pcs = 0; m_mis = 0;
      end else begin
         m_pcs = res && tk;
         m_mis = res && mis;
         if (res) begin
            m_bht[idx] = tk ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                            : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
            m_bcnt++;
            if (mis) m_mcnt++;
         end
      end
   endtask

   task automatic set_br(input bit en, input bit stall, input logic [3:0] cond,
                         input logic [PCW-1:0] pce, input bit pred, input logic [3:0] znvc);
      bus.branch_e = en;  bus.stall_e = stall;  bus.cond_e = cond;
      bus.pc_e = pce;     bus.pred_taken_e = pred;
      {bus.Z, bus.N, bus.V, bus.C} = znvc;
   endtask

   task automatic set_idle();
      set_br(1'b0, 1'b0, 4'($urandom), PCW'($urandom), 1'($urandom), 4'($urandom));
   endtask

   task automatic do_reset();
      set_idle();
      rst_n = 1'b0;
      clk_step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.pc_f = '0;
      do_reset();
      n_cmp++; if ({bus.PC_source, bus.mispredict} !== 2'b00) begin n_fail++;
         $display("FAIL reset_pulses: got %b%b want 00", bus.PC_source, bus.mispredict); end
      n_cmp++; if (bus.branch_count !== 16'd0 || bus.mispredict_count !== 16'd0) begin n_fail++;
         $display("FAIL reset_counts: got %0d/%0d want 0/0", bus.branch_count, bus.mispredict_count); end
      n_cmp++; if (bus4.branch_count !== 4'd0 || bus4.mispredict_count !== 4'd0) begin n_fail++;
         $display("FAIL reset_counts4: got %0d/%0d want 0/0", bus4.branch_count, bus4.mispredict_count); end
      for (int i = 0; i < DEPTH; i++) begin
         bus.pc_f = PCW'(($urandom & 32'hFFF0) | i);
         set_idle();
         clk_step();
         n_cmp++; if (bus.predict_taken_f !== 1'b0) begin n_fail++;
            $display("FAIL reset_sweep idx=%0d: got %b want 0", i, bus.predict_taken_f); end
      end
   endtask

   task automatic test_decode();
      for (int cond = 0; cond < 16; cond++) begin
         for (int f = 0; f < 16; f++) begin
            set_br(1'b1, 1'b0, 4'(cond), PCW'($urandom), 1'b0, 4'(f));
            clk_step();
            n_cmp++; if (bus.PC_source !== m_pcs) begin n_fail++;
               $display("FAIL decode_pcsrc cond=%h znvc=%h: got %b want %b", cond, f, bus.PC_source, m_pcs); end
            n_cmp++; if (bus.mispredict !== m_pcs) begin n_fail++;
               $display("FAIL decode_mispred cond=%h znvc=%h: got %b want %b", cond, f, bus.mispredict, m_pcs); end
         end
      end
      set_idle();
      clk_step();
      n_cmp++; if (bus.branch_count !== 16'(m_bcnt) || bus.mispredict_count !== 16'(m_mcnt)) begin n_fail++;
         $display("FAIL decode_counts: got %0d/%0d want %0d/%0d", bus.branch_count, bus.mispredict_count, m_bcnt, m_mcnt); end
   endtask

   task automatic test_bht_saturate();
      do_reset();
      bus.pc_f = PCW'(5);
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (bus.predict_taken_f !== model_pred(PCW'(5))) begin n_fail++;
            $display("FAIL sat_up step=%0d: got %b want %b", k, bus.predict_taken_f, model_pred(PCW'(5))); end
         set_br(1'b1, 1'b0, 4'hF, PCW'(5), model_pred(PCW'(5)), 4'($urandom));
         clk_step();
      end
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (bus.predict_taken_f !== model_pred(PCW'(5))) begin n_fail++;
            $display("FAIL sat_down step=%0d: got %b want %b", k, bus.predict_taken_f, model_pred(PCW'(5))); end
         set_br(1'b1, 1'b0, 4'hE, PCW'(5), model_pred(PCW'(5)), 4'($urandom));
         clk_step();
         n_cmp++; if (bus.mispredict !== m_mis) begin n_fail++;
            $display("FAIL sat_down_mis step=%0d: got %b want %b", k, bus.mispredict, m_mis); end
      end
      // One taken from the floor must still predict not-taken.
      set_br(1'b1, 1'b0, 4'hF, PCW'(5), 1'b0, 4'($urandom));
      clk_step();
      n_cmp++; if (bus.predict_taken_f !== model_pred(PCW'(5))) begin n_fail++;
         $display("FAIL sat_floor: got %b want %b", bus.predict_taken_f, model_pred(PCW'(5))); end
   endtask

   task automatic test_stall();
      bus.pc_f = PCW'(7);
      set_br(1'b1, 1'b1, 4'hF, PCW'(7), 1'b0, 4'($urandom));
      for (int k = 0; k < 3; k++) begin
         bus.cond_e = 4'($urandom);
         {bus.Z, bus.N, bus.V, bus.C} = 4'($urandom);
         clk_step();
         n_cmp++; if ({bus.PC_source, bus.mispredict} !== 2'b00) begin n_fail++;
            $display("FAIL stall_pulse k=%0d: got %b%b want 00", k, bus.PC_source, bus.mispredict); end
         n_cmp++; if (bus.branch_count !== 16'(m_bcnt) || bus.predict_taken_f !== model_pred(PCW'(7))) begin n_fail++;
            $display("FAIL stall_state k=%0d: got cnt=%0d pred=%b want cnt=%0d pred=%b", k,
                     bus.branch_count, bus.predict_taken_f, m_bcnt, model_pred(PCW'(7))); end
      end
      bus.cond_e = 4'hF;
      bus.stall_e = 1'b0;
      clk_step();
      n_cmp++; if (bus.PC_source !== 1'b1 || bus.branch_count !== 16'(m_bcnt)) begin n_fail++;
         $display("FAIL stall_release: got pcs=%b cnt=%0d want pcs=1 cnt=%0d", bus.PC_source, bus.branch_count, m_bcnt); end
      set_idle();
      clk_step();
      n_cmp++; if (bus.PC_source !== 1'b0 || bus.branch_count !== 16'(m_bcnt)) begin n_fail++;
         $display("FAIL stall_once: got pcs=%b cnt=%0d want pcs=0 cnt=%0d", bus.PC_source, bus.branch_count, m_bcnt); end
   endtask

   task automatic test_same_index();
      do_reset();
      bus.pc_f = PCW'(3);
      set_br(1'b1, 1'b0, 4'hF, PCW'(3), 1'b0, 4'($urandom));
      #1;
      n_cmp++; if (bus.predict_taken_f !== 1'b0) begin n_fail++;
         $display("FAIL same_idx_old: got %b want 0", bus.predict_taken_f); end
      clk_step();
      n_cmp++; if (bus.predict_taken_f !== 1'b1) begin n_fail++;
         $display("FAIL same_idx_new: got %b want 1", bus.predict_taken_f); end
      set_br(1'b1, 1'b0, 4'hF, PCW'(3), 1'b0, 4'($urandom));
      rst_n = 1'b0;
      clk_step();
      rst_n = 1'b1;
      n_cmp++; if ({bus.PC_source, bus.mispredict} !== 2'b00 || bus.branch_count !== 16'd0
                   || bus.mispredict_count !== 16'd0 || bus.predict_taken_f !== 1'b0) begin n_fail++;
         $display("FAIL reset_vs_resolve: got pcs=%b mis=%b cnt=%0d/%0d pred=%b want all 0", bus.PC_source,
                  bus.mispredict, bus.branch_count, bus.mispredict_count, bus.predict_taken_f); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         bus.pc_f = PCW'($urandom);
         set_br(($urandom % 4) != 0, ($urandom % 4) == 0, 4'($urandom), PCW'($urandom),
                1'($urandom), 4'($urandom));
         if ($urandom % 2) bus.pred_taken_e = model_pred(bus.pc_e);
         clk_step();
         n_cmp++; if (bus.PC_source !== m_pcs || bus.mispredict !== m_mis) begin n_fail++;
            $display("FAIL rand_pulse k=%0d: got %b%b want %b%b", k, bus.PC_source, bus.mispredict, m_pcs, m_mis); end
         n_cmp++; if (bus.predict_taken_f !== model_pred(bus.pc_f)) begin n_fail++;
            $display("FAIL rand_pred k=%0d pc=%h: got %b want %b", k, bus.pc_f, bus.predict_taken_f, model_pred(bus.pc_f)); end
         n_cmp++; if (bus.branch_count !== 16'(m_bcnt) || bus.mispredict_count !== 16'(m_mcnt)) begin n_fail++;
            $display("FAIL rand_cnt k=%0d: got %0d/%0d want %0d/%0d", k, bus.branch_count, bus.mispredict_count, m_bcnt, m_mcnt); end
         n_cmp++; if (bus4.branch_count !== 4'(sat4(m_bcnt)) || bus4.mispredict_count !== 4'(sat4(m_mcnt))) begin n_fail++;
            $display("FAIL rand_cnt4 k=%0d: got %0d/%0d want %0d/%0d", k, bus4.branch_count, bus4.mispredict_count,
                     sat4(m_bcnt), sat4(m_mcnt)); end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int k = 0; k < 20; k++) begin
         set_br(1'b1, 1'b0, 4'hF, PCW'($urandom), 1'b0, 4'($urandom));
         clk_step();
      end
      set_idle();
      clk_step();
      n_cmp++; if (bus4.branch_count !== 4'd15 || bus4.mispredict_count !== 4'd15) begin n_fail++;
         $display("FAIL cnt4_saturate: got %0d/%0d want 15/15", bus4.branch_count, bus4.mispredict_count); end
      n_cmp++; if (bus.branch_count !== 16'd20 || bus.mispredict_count !== 16'd20) begin n_fail++;
         $display("FAIL cnt16_count: got %0d/%0d want 20/20", bus.branch_count, bus.mispredict_count); end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.pc_f = '0;
      set_idle();
      for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
      m_bcnt = 0; m_mcnt = 0; m_pcs = 0; m_mis = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_decode();
      test_bht_saturate();
      test_stall();
      test_same_index();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
